// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multiplier pipeline: opcode constants and the
// per-stage bookkeeping entry that travels alongside the operand/product data.
package mips_pkg;

  localparam logic [5:0] OP_SPECIAL2 = 6'h1C;
  localparam logic [5:0] FUNCT_MUL   = 6'h02;
  localparam int         MULT_REG_W  = 5;

  typedef struct packed {
    logic                  valid;
    logic                  is_signed;
    logic                  write_rd;
    logic [MULT_REG_W-1:0] rd;
  } mult_entry_t;

  // Destination reported to the forward/stall unit: zero unless the entry will write rd.
  function automatic logic [MULT_REG_W-1:0] entry_rd(input mult_entry_t e);
    return (e.valid && e.write_rd) ? e.rd : '0;
  endfunction

endpackage

// File: rtl/mult_pipe_stage.sv
// One multiplier pipeline stage: bookkeeping entry plus a data word, advancing every cycle.
// A flush kills whatever would be captured on that edge.
module mult_pipe_stage
  import mips_pkg::*;
#(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  mult_entry_t  entry_d,
  input  logic [W-1:0] data_d,
  output mult_entry_t  entry_q,
  output logic [W-1:0] data_q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      entry_q <= '0;
      data_q  <= '0;
    end else begin
      entry_q       <= entry_d;
      entry_q.valid <= entry_d.valid & ~flush;
      data_q        <= data_d;
    end
  end

endmodule

// File: rtl/mult_pipe_unit.sv
// Four-cycle pipelined multiplier (P1 operands, P2 partial products, P3 sum, OUT register).
// Optional HI/LO state and ports are enabled by defining MULT_HILO_EN.
module mult_pipe_unit
  import mips_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = MULT_REG_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_issue,
  input  logic              i_signed,
  input  logic              i_write_rd,
  input  logic [REG_W-1:0]  i_rd,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic              i_flush,
`ifdef MULT_HILO_EN
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo,
  output logic              o_hilo_busy,
`endif
  output logic [REG_W-1:0]  o_p1_mult_rd,
  output logic [REG_W-1:0]  o_p2_mult_rd,
  output logic [REG_W-1:0]  o_p3_mult_rd,
  output logic              o_mult_ready,
  output logic [REG_W-1:0]  o_mult_rd,
  output logic [DATA_W-1:0] o_mult_result
);

  localparam int H   = DATA_W / 2;
  localparam int PPW = DATA_W + 2;
  localparam int PW  = 2 * DATA_W;

  mult_entry_t p1_d, p1_q, p2_q, p3_q;
  logic [PW-1:0]    p1_data_q;
  logic [4*PPW-1:0] p2_data_d, p2_data_q;
  logic [PW-1:0]    p3_data_d, p3_data_q;

  always_comb begin
    p1_d           = '0;
`ifdef MULT_HILO_EN
    p1_d.valid     = i_issue;
`else
    p1_d.valid     = i_issue & i_write_rd;
`endif
    p1_d.is_signed = i_signed;
    p1_d.write_rd  = i_write_rd;
    p1_d.rd        = i_rd;
  end

  mult_pipe_stage #(.W(PW)) u_p1 (
    .clk(i_clk), .rst(i_rst), .flush(i_flush),
    .entry_d(p1_d), .data_d({i_rs_data, i_rt_data}),
    .entry_q(p1_q), .data_q(p1_data_q)
  );

  // Operands split into halves; upper halves carry the sign only for signed multiplies,
  // so each partial product is an (H+1)x(H+1) signed multiply.
  logic [DATA_W-1:0] op_a, op_b;
  logic signed [H:0] a_hi_x, a_lo_x, b_hi_x, b_lo_x;
  logic signed [PPW-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

  always_comb begin
    op_a   = p1_data_q[PW-1:DATA_W];
    op_b   = p1_data_q[DATA_W-1:0];
    a_hi_x = {p1_q.is_signed & op_a[DATA_W-1], op_a[DATA_W-1:H]};
    a_lo_x = {1'b0, op_a[H-1:0]};
    b_hi_x = {p1_q.is_signed & op_b[DATA_W-1], op_b[DATA_W-1:H]};
    b_lo_x = {1'b0, op_b[H-1:0]};
    pp_ll  = a_lo_x * b_lo_x;
    pp_lh  = a_lo_x * b_hi_x;
    pp_hl  = a_hi_x * b_lo_x;
    pp_hh  = a_hi_x * b_hi_x;
    p2_data_d = {pp_hh, pp_hl, pp_lh, pp_ll};
  end

  mult_pipe_stage #(.W(4*PPW)) u_p2 (
    .clk(i_clk), .rst(i_rst), .flush(i_flush),
    .entry_d(p1_q), .data_d(p2_data_d),
    .entry_q(p2_q), .data_q(p2_data_q)
  );

  logic [PPW-1:0] q_ll, q_lh, q_hl, q_hh;
  logic [PW-1:0]  e_ll, e_lh, e_hl, e_hh;

  // Unsigned partial products are never negative, so extension follows the signed flag.
  always_comb begin
    {q_hh, q_hl, q_lh, q_ll} = p2_data_q;
    e_ll = {{(PW-PPW){p2_q.is_signed & q_ll[PPW-1]}}, q_ll};
    e_lh = {{(PW-PPW){p2_q.is_signed & q_lh[PPW-1]}}, q_lh};
    e_hl = {{(PW-PPW){p2_q.is_signed & q_hl[PPW-1]}}, q_hl};
    e_hh = {{(PW-PPW){p2_q.is_signed & q_hh[PPW-1]}}, q_hh};
    p3_data_d = e_ll + (e_lh << H) + (e_hl << H) + (e_hh << DATA_W);
  end

  mult_pipe_stage #(.W(PW)) u_p3 (
    .clk(i_clk), .rst(i_rst), .flush(i_flush),
    .entry_d(p2_q), .data_d(p3_data_d),
    .entry_q(p3_q), .data_q(p3_data_q)
  );

  assign o_p1_mult_rd = entry_rd(p1_q);
  assign o_p2_mult_rd = entry_rd(p2_q);
  assign o_p3_mult_rd = entry_rd(p3_q);

  logic out_ready_d;
  assign out_ready_d = p3_q.valid & ~i_flush & p3_q.write_rd & (p3_q.rd != '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_mult_ready  <= 1'b0;
      o_mult_rd     <= '0;
      o_mult_result <= '0;
    end else begin
      o_mult_ready  <= out_ready_d;
      o_mult_rd     <= out_ready_d ? p3_q.rd : '0;
      o_mult_result <= out_ready_d ? p3_data_q[DATA_W-1:0] : '0;
    end
  end

`ifdef MULT_HILO_EN
  logic          out_valid;
  logic [PW-1:0] out_prod;

  assign o_hilo_busy = p1_q.valid | p2_q.valid | p3_q.valid;

  // HI/LO load from the OUT register, so they settle one cycle after the ready pulse.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_valid <= 1'b0;
      out_prod  <= '0;
      o_hi      <= '0;
      o_lo      <= '0;
    end else begin
      out_valid <= p3_q.valid & ~i_flush;
      out_prod  <= p3_data_q;
      if (out_valid) begin
        o_hi <= out_prod[PW-1:DATA_W];
        o_lo <= out_prod[DATA_W-1:0];
      end
    end
  end
`endif

endmodule
